branch_ctrl: RTL

Multi-cycle branch/jump resolution controller for the rv32i core. It accepts one control-transfer request at a time from decode, evaluates the condition with the branch comparator, computes and checks the target, and drives a redirect handshake plus a flush pulse to fetch. It sits between the register-file read stage and the PC/fetch logic, and is the only block that sequences the branch comparator.

---
 rtl/branch_ctrl_pkg.sv | 21 ++
 rtl/branch_ctrl_if.sv | 33 +++
 rtl/branch_ctrl_cmp.sv | 32 +++
 rtl/branch_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared rv32i definitions used by the branch controller and its comparator:
// the brOp encodings and the controller state enum.
package rv32i_pkg;

  // brOp encodings; 00XXX means no transfer, 1XXXX is an unconditional jump
  localparam logic [4:0] BR_NONE    = 5'b00000;
  localparam logic [4:0] BR_EQ      = 5'b01000;
  localparam logic [4:0] BR_NE      = 5'b01001;
  localparam logic [4:0] BR_LT      = 5'b01100;
  localparam logic [4:0] BR_GE      = 5'b01101;
  localparam logic [4:0] BR_LTU     = 5'b01110;
  localparam logic [4:0] BR_GEU     = 5'b01111;
  localparam int         BR_JMP_MSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    REDIR = 2'd2
  } brCtrlState_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode request / fetch redirect bundle of the branch controller.
// master = decode+fetch side, slave = branch_ctrl.
interface branch_ctrl_if #(parameter int XLEN = 32);

  logic            req_valid;
  logic            req_ready;
  logic [4:0]      req_brOp;
  logic            req_jalr;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_imm;
  logic            redir_valid;
  logic            redir_ready;
  logic [XLEN-1:0] redir_pc;
  logic            flush;
  logic            done;
  logic            done_taken;
  logic            misalign;

  modport master (
    output req_valid, req_brOp, req_jalr, req_rs1, req_rs2, req_pc, req_imm,
    output redir_ready,
    input  req_ready, redir_valid, redir_pc, flush, done, done_taken, misalign
  );

  modport slave (
    input  req_valid, req_brOp, req_jalr, req_rs1, req_rs2, req_pc, req_imm,
    input  redir_ready,
    output req_ready, redir_valid, redir_pc, flush, done, done_taken, misalign
  );

endinterface

// File: rtl/branch_ctrl_cmp.sv
// br_cmp: combinational branch condition evaluator.
// Unconditional jumps always take; no-op and undefined encodings never take.
module br_cmp
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      i_brOp,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_taken
);

  // Decode the op and evaluate the signed/unsigned relation
  always_comb begin
    o_taken = 1'b0;
    if (i_brOp[BR_JMP_MSB]) begin
      o_taken = 1'b1;
    end else begin
      case (i_brOp)
        BR_EQ:   o_taken = (i_rs1 == i_rs2);
        BR_NE:   o_taken = (i_rs1 != i_rs2);
        BR_LT:   o_taken = ($signed(i_rs1) <  $signed(i_rs2));
        BR_GE:   o_taken = ($signed(i_rs1) >= $signed(i_rs2));
        BR_LTU:  o_taken = (i_rs1 <  i_rs2);
        BR_GEU:  o_taken = (i_rs1 >= i_rs2);
        default: o_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: multi-cycle branch/jump resolution controller.
// IDLE latches a request, EVAL resolves condition and target, REDIR holds
// the redirect until fetch accepts it.
// Optional feature macro: BRANCH_CTRL_STATS_EN adds stat_total/stat_taken.
module branch_ctrl
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  branch_ctrl_if.slave bus
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [31:0] stat_total,
  output logic [31:0] stat_taken
`endif
);

  brCtrlState_t    r_state;
  brCtrlState_t    w_nextState;
  logic [4:0]      r_brOp;
  logic            r_jalr;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_redirPc;

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_target;
  logic            w_taken;
  logic            w_misal;
  logic            w_accept;
  logic            w_goRedir;
  logic            w_flush;
  logic            w_done;
  logic            w_doneTaken;
  logic            w_misalign;

  br_cmp #(.XLEN(XLEN)) u_cmp (
    .i_brOp  (r_brOp),
    .i_rs1   (r_rs1),
    .i_rs2   (r_rs2),
    .o_taken (w_taken)
  );

  // Target adder works only on latched fields so no req_* input reaches an output
  always_comb begin
    w_base   = r_jalr ? r_rs1 : r_pc;
    w_sum    = w_base + r_imm;
    w_target = r_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
    w_misal  = (w_target[1:0] != 2'b00);
  end

  assign w_accept  = (r_state == IDLE) && bus.req_valid;
  assign w_goRedir = (r_state == EVAL) && w_taken && !w_misal;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid) w_nextState = EVAL;
      EVAL:    w_nextState = w_goRedir ? REDIR : IDLE;
      REDIR:   if (bus.redir_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Capture the request fields on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brOp <= '0;
      r_jalr <= 1'b0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_pc   <= '0;
      r_imm  <= '0;
    end else if (w_accept) begin
      r_brOp <= bus.req_brOp;
      r_jalr <= bus.req_jalr;
      r_rs1  <= bus.req_rs1;
      r_rs2  <= bus.req_rs2;
      r_pc   <= bus.req_pc;
      r_imm  <= bus.req_imm;
    end
  end

  // Hold the redirect target from EVAL until the next redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirPc <= '0;
    end else if (w_goRedir) begin
      r_redirPc <= w_target;
    end
  end

  // Handshake pulses: flush coincides with the redirect being taken by fetch
  always_comb begin
    w_flush     = (r_state == REDIR) && bus.redir_ready;
    w_misalign  = (r_state == EVAL) && w_taken && w_misal;
    w_done      = ((r_state == EVAL) && !w_goRedir) || w_flush;
    w_doneTaken = w_misalign || w_flush;
  end

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.redir_valid = (r_state == REDIR);
  assign bus.redir_pc    = r_redirPc;
  assign bus.flush       = w_flush;
  assign bus.done        = w_done;
  assign bus.done_taken  = w_doneTaken;
  assign bus.misalign    = w_misalign;

`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] r_statTotal;
  logic [31:0] r_statTaken;

  // Retirement counters, wrapping naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_statTotal <= '0;
      r_statTaken <= '0;
    end else begin
      if (w_done) r_statTotal <= r_statTotal + 32'd1;
      if (w_done && w_doneTaken) r_statTaken <= r_statTaken + 32'd1;
    end
  end

  assign stat_total = r_statTotal;
  assign stat_taken = r_statTaken;
`endif

endmodule
